bullet_fire_ctrl: RTL and testbench
===================================

// Module: bullet_fire_ctrl
// PURPOSE
//  Initiator side of the bullet create handshake: turns a fire key in the USB keycode into one create request per press
//  and sends it to a free bullet slot. Sits between keycode decode and a bank of NUM_BULLETS bullet instances for one tank.
//  Handles slot choice, ack by is_bullet_active, cooldown and drop reporting.
// PARAMETERS
//  NUM_BULLETS  5      bullet slots owned by this tank (2..8)
//  FIRE_KEY     8'h2C  USB HID usage code that fires (space)
//  COOLDOWN     15     frames after a shot before the next press is accepted (1..255)
//  ACK_TIMEOUT  4      frames to wait for slot active before a request is abandoned (2..15)
// PORTS
//  frame_clk      in   1            frame-rate clock; all state on its rising edge
//  Reset          in   1            synchronous, active-high
//  keycode        in   32           four packed HID key bytes, [7:0] first
//  tank_alive     in   1            0 = tank destroyed; fire requests are blocked
//  bullet_active  in   NUM_BULLETS  is_bullet_active from each bullet slot; the ack
//  create         out  NUM_BULLETS  one-hot create level to each bullet slot, registered
//  busy           out  1            1 in REQ or COOL state
//  fire_drop      out  1            one-cycle pulse: press lost (no free slot or ack timeout)
//  shots_fired    out  8            count of acked shots; saturates at 255
// BEHAVIOUR
//  Reset (sync): create=0, busy=0, fire_drop=0, shots_fired=0, rr_ptr=0, state=IDLE, key_q=0, cool_cnt=0, ack_cnt=0.
//  pressed = (any keycode byte == FIRE_KEY). key_q <= pressed. press_edge = pressed & ~key_q, one event per press.
//  Holding the key never re-fires. A press_edge that arrives outside IDLE is discarded, not queued.
//  Free slot search: starting at rr_ptr and wrapping modulo NUM_BULLETS, pick the first index i with bullet_active[i]==0.
//  FSM (state_t: IDLE, REQ, COOL):
//   IDLE: on press_edge & tank_alive:
//     - free slot found: slot<=i, create<=onehot(i), ack_cnt<=0, go to REQ.
//     - no free slot: fire_drop pulses, stay in IDLE.
//     - press_edge while tank_alive=0: ignored, no drop pulse.
//   REQ: create stays constant.
//     - bullet_active[slot]==1 (ack): create<=0 on the same edge, shots_fired+=1 (saturating),
//       rr_ptr<=(slot+1) mod N, cool_cnt<=COOLDOWN, go to COOL.
//     - no ack after ACK_TIMEOUT frames in REQ: create<=0, fire_drop pulses, go to COOL (cool_cnt<=COOLDOWN).
//       If ack and timeout fall on the same frame, ack wins.
//     - tank_alive==0 (abort): create<=0, go to IDLE, no drop pulse, no count. Abort has priority over ack and timeout.
//   COOL: cool_cnt-=1 each frame; when cool_cnt==1, go to IDLE next edge, so the block is busy COOLDOWN frames.
//  Latency: press_edge at edge k -> create high after edge k. The bullet registers create, then goes active,
//   so the ack is normally seen 2 frames later and create drops at edge k+3.
//  create must drop on the ack. If it is held, the bullet re-fires by itself when its lifetime timer expires.
//  create is never high on more than one bit, and never high outside REQ.
//  Reset in mid-REQ: create drops at that edge; bullet slots are not touched.
//  rr_ptr and slot widths are $clog2(NUM_BULLETS). The wrap uses compare-and-clear, not a power-of-2 mask.
// STRUCTURE
//  tank_pkg: state_t enum {IDLE,REQ,COOL}; KEY_SPACE=8'h2C; MAX_BULLETS=8.
//  Sub-module rr_free_slot (combinational): inputs mask and start pointer; outputs found and index.
//   Rotate-priority search; tested on its own.
//  Top: key match/edge detect, FSM, counters, output registers.
// TESTING
//  T1 press 8'h2C in byte 2 for 10 frames, all slots idle, ack model 2 frames -> create=5'b00001 for 3 frames,
//     shots_fired=1, one shot only, busy for 3+15 frames.
//  T2 five presses spaced 20 frames, slots stay active -> create hits slots 0,1,2,3,4 in order;
//     sixth press -> fire_drop=1 for 1 cycle, create stays 0.
//  T3 slot never acks -> create high exactly 4 frames, fire_drop pulses once, shots_fired unchanged, then COOL.
//  T4 press during COOL (frame 5 of 15) -> ignored; press after busy falls -> fires normally.
//  T5 tank_alive falls 1 frame into REQ -> create=0 next edge, state IDLE, no drop, count unchanged.
//  T6 Reset asserted mid-REQ and ack and timeout on the same frame (separate runs) -> all outputs 0;
//     ack wins, count+1, no drop.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared types and constants for the tank firing logic.
package tank_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        COOL = 2'd2
    } state_t;

    localparam logic [7:0] KEY_SPACE   = 8'h2C;
    localparam int         MAX_BULLETS = 8;

endpackage

// File: rtl/rr_free_slot.sv
// Rotate-priority search for the first clear bit of mask, starting at start and wrapping at N.
module rr_free_slot #(
    parameter int N = 5,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] index
);

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    logic [W-1:0] idx_s;

    // Walk every slot once from start; N need not be a power of two, so wrap by compare-and-clear.
    always_comb begin
        found = 1'b0;
        index = {W{1'b0}};
        idx_s = start;
        for (int i = 0; i < N; i++) begin
            if (!found && !mask[idx_s]) begin
                found = 1'b1;
                index = idx_s;
            end else begin
                index = index;
            end
            if (idx_s == LAST_IDX) begin
                idx_s = {W{1'b0}};
            end else begin
                idx_s = idx_s + W'(1);
            end
        end
    end

endmodule

// File: rtl/bullet_fire_ctrl.sv
// Turns a fire-key press into one create request to a free bullet slot, waits for the slot
// to go active, then holds off further shots for a cooldown period.
module bullet_fire_ctrl
    import tank_pkg::*;
#(
    parameter int         NUM_BULLETS = 5,
    parameter logic [7:0] FIRE_KEY    = KEY_SPACE,
    parameter int         COOLDOWN    = 15,
    parameter int         ACK_TIMEOUT = 4
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic [31:0]            keycode,
    input  logic                   tank_alive,
    input  logic [NUM_BULLETS-1:0] bullet_active,
    output logic [NUM_BULLETS-1:0] create,
    output logic                   busy,
    output logic                   fire_drop,
    output logic [7:0]             shots_fired
);

    localparam int               SW        = $clog2(NUM_BULLETS);
    localparam logic [SW-1:0]    LAST_SLOT = SW'(NUM_BULLETS - 1);
    localparam logic [7:0]       COOL_INIT = 8'(COOLDOWN);
    localparam logic [3:0]       ACK_LAST  = 4'(ACK_TIMEOUT - 1);
    localparam logic [NUM_BULLETS-1:0] ONE_N = {{(NUM_BULLETS-1){1'b0}}, 1'b1};

    state_t                 state_r, state_nxt_s;
    logic                   key_q_r;
    logic [NUM_BULLETS-1:0] create_r, create_nxt_s;
    logic                   busy_r, busy_nxt_s;
    logic                   drop_r, drop_nxt_s;
    logic [7:0]             shots_r, shots_nxt_s;
    logic [SW-1:0]          rr_ptr_r, rr_ptr_nxt_s;
    logic [SW-1:0]          slot_r, slot_nxt_s;
    logic [7:0]             cool_cnt_r, cool_cnt_nxt_s;
    logic [3:0]             ack_cnt_r, ack_cnt_nxt_s;

    logic                   pressed_s;
    logic                   press_edge_s;
    logic                   free_found_s;
    logic [SW-1:0]          free_idx_s;
    logic [SW-1:0]          slot_after_s;
    logic [7:0]             shots_inc_s;

    assign pressed_s    = (keycode[7:0]   == FIRE_KEY) || (keycode[15:8]  == FIRE_KEY) ||
                          (keycode[23:16] == FIRE_KEY) || (keycode[31:24] == FIRE_KEY);
    assign press_edge_s = pressed_s & ~key_q_r;
    assign slot_after_s = (slot_r == LAST_SLOT) ? {SW{1'b0}} : slot_r + SW'(1);
    assign shots_inc_s  = (shots_r == 8'hFF) ? shots_r : shots_r + 8'd1;

    rr_free_slot #(
        .N (NUM_BULLETS),
        .W (SW)
    ) u_free_slot (
        .mask  (bullet_active),
        .start (rr_ptr_r),
        .found (free_found_s),
        .index (free_idx_s)
    );

    // Next-state and next-output logic for the request handshake.
    always_comb begin
        state_nxt_s    = state_r;
        create_nxt_s   = create_r;
        slot_nxt_s     = slot_r;
        ack_cnt_nxt_s  = ack_cnt_r;
        cool_cnt_nxt_s = cool_cnt_r;
        rr_ptr_nxt_s   = rr_ptr_r;
        shots_nxt_s    = shots_r;
        drop_nxt_s     = 1'b0;
        case (state_r)
            IDLE: begin
                create_nxt_s = {NUM_BULLETS{1'b0}};
                if (press_edge_s && tank_alive) begin
                    if (free_found_s) begin
                        slot_nxt_s    = free_idx_s;
                        create_nxt_s  = ONE_N << free_idx_s;
                        ack_cnt_nxt_s = 4'd0;
                        state_nxt_s   = REQ;
                    end else begin
                        drop_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                // Abort beats ack, and ack beats timeout on the same frame.
                if (!tank_alive) begin
                    create_nxt_s = {NUM_BULLETS{1'b0}};
                    state_nxt_s  = IDLE;
                end else if (bullet_active[slot_r]) begin
                    create_nxt_s   = {NUM_BULLETS{1'b0}};
                    shots_nxt_s    = shots_inc_s;
                    rr_ptr_nxt_s   = slot_after_s;
                    cool_cnt_nxt_s = COOL_INIT;
                    state_nxt_s    = COOL;
                end else if (ack_cnt_r == ACK_LAST) begin
                    create_nxt_s   = {NUM_BULLETS{1'b0}};
                    drop_nxt_s     = 1'b1;
                    cool_cnt_nxt_s = COOL_INIT;
                    state_nxt_s    = COOL;
                end else begin
                    ack_cnt_nxt_s = ack_cnt_r + 4'd1;
                end
            end
            COOL: begin
                create_nxt_s   = {NUM_BULLETS{1'b0}};
                cool_cnt_nxt_s = cool_cnt_r - 8'd1;
                if (cool_cnt_r <= 8'd1) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = COOL;
                end
            end
            default: begin
                create_nxt_s = {NUM_BULLETS{1'b0}};
                state_nxt_s  = IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_r    <= IDLE;
            key_q_r    <= 1'b0;
            create_r   <= {NUM_BULLETS{1'b0}};
            busy_r     <= 1'b0;
            drop_r     <= 1'b0;
            shots_r    <= 8'd0;
            rr_ptr_r   <= {SW{1'b0}};
            slot_r     <= {SW{1'b0}};
            cool_cnt_r <= 8'd0;
            ack_cnt_r  <= 4'd0;
        end else begin
            state_r    <= state_nxt_s;
            key_q_r    <= pressed_s;
            create_r   <= create_nxt_s;
            busy_r     <= busy_nxt_s;
            drop_r     <= drop_nxt_s;
            shots_r    <= shots_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
            slot_r     <= slot_nxt_s;
            cool_cnt_r <= cool_cnt_nxt_s;
            ack_cnt_r  <= ack_cnt_nxt_s;
        end
    end

    assign create      = create_r;
    assign busy        = busy_r;
    assign fire_drop   = drop_r;
    assign shots_fired = shots_r;

endmodule

// File: tb/tb_bullet_fire_ctrl.sv
// Scoreboard bench for bullet_fire_ctrl: each driven frame queues the outputs expected after that edge.
module tb_bullet_fire_ctrl;

    typedef struct {
        string      tag;
        logic [4:0] create;
        logic       busy;
        logic       drop;
        logic [7:0] shots;
    } exp_t;

    localparam logic [31:0] KC_B0   = 32'h0000_002C;
    localparam logic [31:0] KC_B2   = 32'h002C_0000;
    localparam logic [31:0] KC_B3   = 32'h2C04_0500;
    localparam logic [31:0] KC_NONE = 32'h0000_0000;
    localparam logic [31:0] KC_MISC = 32'h0504_1A2B;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [31:0] keycode;
    logic        tank_alive;
    logic [4:0]  bullet_active;
    logic [4:0]  create;
    logic        busy;
    logic        fire_drop;
    logic [7:0]  shots_fired;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    bullet_fire_ctrl dut (
        .frame_clk     (frame_clk),
        .Reset         (Reset),
        .keycode       (keycode),
        .tank_alive    (tank_alive),
        .bullet_active (bullet_active),
        .create        (create),
        .busy          (busy),
        .fire_drop     (fire_drop),
        .shots_fired   (shots_fired)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one frame of inputs, queue the outputs expected after the next edge.
    task automatic drive(input string tag, input logic rst, input logic [31:0] kc, input logic alive,
                         input logic [4:0] act, input logic [4:0] e_create, input logic e_busy,
                         input logic e_drop, input logic [7:0] e_shots);
        exp_t e;
        Reset         = rst;
        keycode       = kc;
        tank_alive    = alive;
        bullet_active = act;
        e.tag    = tag;
        e.create = e_create;
        e.busy   = e_busy;
        e.drop   = e_drop;
        e.shots  = e_shots;
        sb_q.push_back(e);
        @(posedge frame_clk);
        #2;
    endtask

    task automatic do_reset(input string tag);
        for (int i = 0; i < 2; i++) begin
            drive($sformatf("%s rst%0d", tag, i), 1'b1, KC_NONE, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0, 8'd0);
        end
    endtask

    // Compare DUT outputs just after each active edge against the oldest queued expectation.
    always @(posedge frame_clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk({mon_e.tag, " create"}, 32'(create),      32'(mon_e.create));
            chk({mon_e.tag, " busy"},   32'(busy),        32'(mon_e.busy));
            chk({mon_e.tag, " drop"},   32'(fire_drop),   32'(mon_e.drop));
            chk({mon_e.tag, " shots"},  32'(shots_fired), 32'(mon_e.shots));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [4:0]  act_v;
        logic [31:0] kc_v;
        logic [4:0]  oh_v;

        // T0: non-fire keys do nothing
        do_reset("T0");
        for (int j = 0; j < 4; j++) begin
            drive($sformatf("T0 f%0d", j), 1'b0, KC_MISC, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0, 8'd0);
        end

        // T1: held key in byte 2, ack two frames after create
        do_reset("T1");
        for (int j = 0; j < 22; j++) begin
            kc_v  = (j < 10) ? KC_B2 : KC_NONE;
            act_v = (j >= 3) ? 5'b00001 : 5'b00000;
            drive($sformatf("T1 f%0d", j), 1'b0, kc_v, 1'b1, act_v,
                  (j < 3) ? 5'b00001 : 5'b00000, (j < 18), 1'b0, (j >= 3) ? 8'd1 : 8'd0);
        end

        // T2: five spaced presses fill slots 0..4 in order, sixth press drops
        do_reset("T2");
        act_v = 5'b00000;
        for (int p = 0; p < 5; p++) begin
            oh_v = 5'b00001 << p;
            for (int j = 0; j < 20; j++) begin
                if (j == 3) act_v[p] = 1'b1;
                drive($sformatf("T2 p%0d f%0d", p, j), 1'b0, (j < 2) ? KC_B0 : KC_NONE, 1'b1, act_v,
                      (j < 3) ? oh_v : 5'b00000, (j < 18), 1'b0, (j >= 3) ? 8'(p + 1) : 8'(p));
            end
        end
        for (int j = 0; j < 5; j++) begin
            drive($sformatf("T2 full f%0d", j), 1'b0, (j < 2) ? KC_B3 : KC_NONE, 1'b1, act_v,
                  5'b00000, 1'b0, (j == 0), 8'd5);
        end
        // rr_ptr wrapped to 0: slots 0 and 2 free picks 0, then the search starts at 1 and picks 2
        act_v = 5'b11010;
        for (int j = 0; j < 20; j++) begin
            if (j == 3) act_v[0] = 1'b1;
            drive($sformatf("T2 wrap f%0d", j), 1'b0, (j < 2) ? KC_B0 : KC_NONE, 1'b1, act_v,
                  (j < 3) ? 5'b00001 : 5'b00000, (j < 18), 1'b0, (j >= 3) ? 8'd6 : 8'd5);
        end
        act_v = 5'b11010;
        for (int j = 0; j < 20; j++) begin
            if (j == 3) act_v[2] = 1'b1;
            drive($sformatf("T2 rot f%0d", j), 1'b0, (j < 2) ? KC_B0 : KC_NONE, 1'b1, act_v,
                  (j < 3) ? 5'b00100 : 5'b00000, (j < 18), 1'b0, (j >= 3) ? 8'd7 : 8'd6);
        end

        // T3: slot never acks
        do_reset("T3");
        for (int j = 0; j < 22; j++) begin
            drive($sformatf("T3 f%0d", j), 1'b0, (j < 2) ? KC_B2 : KC_NONE, 1'b1, 5'b00000,
                  (j < 4) ? 5'b00001 : 5'b00000, (j < 19), (j == 4), 8'd0);
        end

        // T4: press during cooldown ignored, press after busy falls fires slot 1
        do_reset("T4");
        for (int j = 0; j < 40; j++) begin
            kc_v  = (j == 0 || j == 1 || j == 8 || j == 9 || j == 20 || j == 21) ? KC_B0 : KC_NONE;
            act_v = {3'b000, (j >= 23), (j >= 3)};
            if (j < 3)       oh_v = 5'b00001;
            else if (j >= 20 && j < 23) oh_v = 5'b00010;
            else             oh_v = 5'b00000;
            drive($sformatf("T4 f%0d", j), 1'b0, kc_v, 1'b1, act_v, oh_v,
                  (j < 18) || (j >= 20 && j < 38), 1'b0, (j >= 23) ? 8'd2 : ((j >= 3) ? 8'd1 : 8'd0));
        end

        // T5: tank dies one frame into REQ; presses while dead are ignored
        do_reset("T5");
        for (int j = 0; j < 10; j++) begin
            kc_v = (j < 2 || j == 3 || j == 4) ? KC_B2 : KC_NONE;
            drive($sformatf("T5 f%0d", j), 1'b0, kc_v, !(j >= 1 && j < 6), 5'b00000,
                  (j == 0) ? 5'b00001 : 5'b00000, (j == 0), 1'b0, 8'd0);
        end

        // T6b: ack lands on the timeout frame, ack wins
        do_reset("T6b");
        for (int j = 0; j < 21; j++) begin
            drive($sformatf("T6b f%0d", j), 1'b0, (j < 2) ? KC_B0 : KC_NONE, 1'b1,
                  (j >= 4) ? 5'b00001 : 5'b00000, (j < 4) ? 5'b00001 : 5'b00000,
                  (j < 19), 1'b0, (j >= 4) ? 8'd1 : 8'd0);
        end

        // T6a: Reset mid-REQ clears every output including the shot count
        drive("T6a f0", 1'b0, KC_B0, 1'b1, 5'b00001, 5'b00010, 1'b1, 1'b0, 8'd1);
        drive("T6a f1", 1'b1, KC_NONE, 1'b1, 5'b00001, 5'b00000, 1'b0, 1'b0, 8'd0);
        for (int j = 2; j < 6; j++) begin
            drive($sformatf("T6a f%0d", j), 1'b0, KC_NONE, 1'b1, 5'b00001, 5'b00000, 1'b0, 1'b0, 8'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
